// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: four-requester, zero-latency round-robin write arbiter in
// front of a shared FIFO.
//
// Optional feature: define FIFO_ARB_BURST_EN to enable burst locking. A
// winner then keeps the FIFO until it writes a word with req_last set.
// The default build has no burst FSM and ignores req_last.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous, active-high reset
//   req[4]       per-requester write request
//   req_data     requester i's word in bits [i*B +: B]
//   req_last[4]  burst-end marker, used only with FIFO_ARB_BURST_EN
//   ack[4]       one-hot acceptance of the winner's word this cycle (combinational)
//   fifo_full    full flag from the shared FIFO
//   fifo_wr      write strobe to the shared FIFO (combinational)
//   fifo_w_data  winner's word, or 0 when there is no write (combinational)
//   stall_cnt    saturating count of cycles with a request blocked by fifo_full
module fifo_wr_arb #(
  parameter int unsigned B  = 8,
  parameter int unsigned SW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      req,
  input  logic [4*B-1:0]  req_data,
  input  logic [3:0]      req_last,
  output logic [3:0]      ack,
  input  logic            fifo_full,
  output logic            fifo_wr,
  output logic [B-1:0]    fifo_w_data,
  output logic [SW-1:0]   stall_cnt
);

  localparam int unsigned NREQ = 4;

  logic [1:0] ptr;
  logic [1:0] ptr_nxt;
  logic [3:0] elig;
  logic [1:0] win;
  logic       found;
  logic       wr_c;

`ifdef FIFO_ARB_BURST_EN
  typedef enum logic {IDLE, LOCK} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] owner;
  logic [1:0] owner_nxt;

  // While locked only the burst owner may compete.
  always_comb begin
    elig = req;
    if (state == LOCK) elig = req & (4'b0001 << owner);
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;

  always_comb begin
    elig = req;
  end
`endif

  // Round-robin search starting at ptr; 2-bit index addition wraps modulo 4.
  always_comb begin
    logic [1:0] idx;
    found = 1'b0;
    win   = 2'd0;
    idx   = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Reset gates the write so nothing reaches the FIFO while reset is held.
  assign wr_c        = found & ~fifo_full & ~reset;
  assign fifo_wr     = wr_c;
  assign ack         = wr_c ? (4'b0001 << win) : 4'b0000;
  assign fifo_w_data = wr_c ? req_data[32'(win)*B +: B] : '0;

`ifdef FIFO_ARB_BURST_EN
  // Burst-lock next state; the pointer only advances when a burst ends.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    if (wr_c) begin
      case (state)
        IDLE: begin
          if (req_last[win]) begin
            ptr_nxt = win + 2'd1;
          end else begin
            state_nxt = LOCK;
            owner_nxt = win;
          end
        end
        LOCK: begin
          if (req_last[owner]) begin
            state_nxt = IDLE;
            ptr_nxt   = owner + 2'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= 2'd0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end
`else
  // Every accepted word moves priority to the requester after the winner.
  always_comb begin
    ptr_nxt = ptr;
    if (wr_c) ptr_nxt = win + 2'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) ptr <= 2'd0;
    else       ptr <= ptr_nxt;
  end

  // Count cycles where some request is blocked by a full FIFO; saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if ((|req) && fifo_full && (stall_cnt != {SW{1'b1}})) begin
      stall_cnt <= stall_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: self-checking bench for fifo_wr_arb. Directed vector table,
// hand-written corner sequences and randomized traffic, all checked against a
// behavioural arbitration model kept in the bench.
module tb_fifo_wr_arb;

  localparam int unsigned B    = 8;
  localparam int unsigned SW   = 4;
  localparam int          SMAX = (1 << SW) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      req;
  logic [4*B-1:0]  req_data;
  logic [3:0]      req_last;
  logic [3:0]      ack;
  logic            fifo_full;
  logic            fifo_wr;
  logic [B-1:0]    fifo_w_data;
  logic [SW-1:0]   stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: priority pointer, stall count, burst lock and owner.
  int m_ptr   = 0;
  int m_stall = 0;
  bit m_lock  = 1'b0;
  int m_owner = 0;

  fifo_wr_arb #(.B(B), .SW(SW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .req_last    (req_last),
    .ack         (ack),
    .fifo_full   (fifo_full),
    .fifo_wr     (fifo_wr),
    .fifo_w_data (fifo_w_data),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time bound reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, check combinational outputs mid-cycle against the model,
  // advance the model across the clock edge, then check stall_cnt.
  task automatic apply(input logic r, input logic [3:0] rq, input logic [4*B-1:0] d,
                       input logic [3:0] lst, input logic f,
                       output logic [3:0] ack_s, output logic wr_s,
                       output logic [B-1:0] data_s, output int stall_s);
    int elig;
    int win;
    bit e_wr;
    int e_data;
    reset = r; req = rq; req_data = d; req_last = lst; fifo_full = f;
    elig = m_lock ? (int'(rq) & (1 << m_owner)) : int'(rq);
    win = -1;
    for (int k = 0; k < 4; k++) begin
      if (win < 0 && elig[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
    end
    e_wr   = (win >= 0) && !f && !r;
    e_data = e_wr ? int'(d[win*B +: B]) : 0;
    @(negedge clk);
    ack_s = ack; wr_s = fifo_wr; data_s = fifo_w_data;
    check("ack", int'(ack), e_wr ? (1 << win) : 0);
    check("fifo_wr", int'(fifo_wr), int'(e_wr));
    check("fifo_w_data", int'(fifo_w_data), e_data);
    if (r) begin
      m_ptr = 0; m_stall = 0; m_lock = 1'b0; m_owner = 0;
    end else begin
      if (f && rq != 4'b0000 && m_stall < SMAX) m_stall++;
      if (e_wr) begin
`ifdef FIFO_ARB_BURST_EN
        if (!m_lock) begin
          if (lst[win]) m_ptr = (win + 1) % 4;
          else begin m_lock = 1'b1; m_owner = win; end
        end else if (lst[m_owner]) begin
          m_lock = 1'b0; m_ptr = (m_owner + 1) % 4;
        end
`else
        m_ptr = (win + 1) % 4;
`endif
      end
    end
    @(posedge clk);
    #1;
    stall_s = int'(stall_cnt);
    check("stall_cnt", int'(stall_cnt), m_stall);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] rq;
    logic       full;
    logic [3:0] e_ack;
    logic       e_wr;
    logic [7:0] e_data;
    int         e_stall;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic f,
                     input logic [3:0] ea, input logic ew, input logic [7:0] ed, input int es);
    vec_t v;
    v.rst = r; v.rq = rq; v.full = f; v.e_ack = ea; v.e_wr = ew; v.e_data = ed; v.e_stall = es;
    tbl.push_back(v);
  endtask

  initial begin
    logic [3:0]     a_s;
    logic           w_s;
    logic [B-1:0]   d_s;
    int             s_s;
    logic [4*B-1:0] words;
    logic [3:0]     acc;
    words = 32'hA3A2A1A0;
    reset = 1'b1; req = '0; req_data = '0; req_last = '0; fifo_full = 1'b0;

    // Reset, round-robin sweep, blocked request, pointer wrap, reset priority.
    add(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 0);
    add(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 8'hA0, 0);
    add(1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1, 8'hA1, 0);
    add(1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1, 8'hA2, 0);
    add(1'b0, 4'b1111, 1'b0, 4'b1000, 1'b1, 8'hA3, 0);
    for (int i = 1; i <= 5; i++) add(1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 8'h00, i);
    add(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 8'hA2, 5);
    add(1'b0, 4'b1001, 1'b0, 4'b1000, 1'b1, 8'hA3, 5);
    add(1'b0, 4'b1001, 1'b0, 4'b0001, 1'b1, 8'hA0, 5);
    add(1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1, 8'hA1, 5);
    add(1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0, 8'h00, 0);
    add(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 8'hA0, 0);
    add(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 0);

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].rq, words, 4'b1111, tbl[i].full, a_s, w_s, d_s, s_s);
      check($sformatf("vec%0d_ack", i), int'(a_s), int'(tbl[i].e_ack));
      check($sformatf("vec%0d_wr", i), int'(w_s), int'(tbl[i].e_wr));
      check($sformatf("vec%0d_data", i), int'(d_s), int'(tbl[i].e_data));
      check($sformatf("vec%0d_stall", i), s_s, tbl[i].e_stall);
    end

    // Stall counter saturation and hold.
    apply(1'b1, 4'b0000, words, 4'b1111, 1'b0, a_s, w_s, d_s, s_s);
    for (int i = 1; i <= SMAX + 5; i++) begin
      apply(1'b0, 4'b0001, words, 4'b1111, 1'b1, a_s, w_s, d_s, s_s);
      check("sat_stall", s_s, (i < SMAX) ? i : SMAX);
      check("sat_no_wr", int'(w_s), 0);
    end

    // Fairness: all four requesters acked once in each 4-cycle window.
    apply(1'b1, 4'b0000, words, 4'b1111, 1'b0, a_s, w_s, d_s, s_s);
    for (int w = 0; w < 3; w++) begin
      acc = 4'b0000;
      for (int c = 0; c < 4; c++) begin
        apply(1'b0, 4'b1111, words, 4'b1111, 1'b0, a_s, w_s, d_s, s_s);
        check("fair_onehot", int'($countones(a_s)), 1);
        acc = acc | a_s;
      end
      check("fair_window", int'(acc), 15);
    end

`ifdef FIFO_ARB_BURST_EN
    // Burst: req0 holds the FIFO for three words, req1 follows.
    apply(1'b1, 4'b0000, words, 4'b0000, 1'b0, a_s, w_s, d_s, s_s);
    apply(1'b0, 4'b0011, words, 4'b0010, 1'b0, a_s, w_s, d_s, s_s);
    check("burst_ack1", int'(a_s), 1);
    apply(1'b0, 4'b0011, words, 4'b0010, 1'b0, a_s, w_s, d_s, s_s);
    check("burst_ack2", int'(a_s), 1);
    apply(1'b0, 4'b0011, words, 4'b0011, 1'b0, a_s, w_s, d_s, s_s);
    check("burst_ack3", int'(a_s), 1);
    apply(1'b0, 4'b0010, words, 4'b0010, 1'b0, a_s, w_s, d_s, s_s);
    check("burst_ack4", int'(a_s), 2);
`endif

    // Randomized traffic with occasional reset and full.
    for (int i = 0; i < 600; i++) begin
      apply(($urandom % 40) == 0, 4'($urandom), 32'($urandom), 4'($urandom),
            ($urandom % 4) == 0, a_s, w_s, d_s, s_s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
